// File: rtl/pc_link_stack.sv
// pc_link_stack: a return-address stack that drives the program counter's
// load / load_address jump request.
//   call     : pushes pc_current+1 and issues a one-cycle jump to call_target.
//   irq_take : pushes pc_current+1 only. The PC performs the vector jump itself.
//   ret      : pops the saved address and jumps to it three cycles later.
//              busy is high in between, and all requests are ignored then.
//
// Ports
//   clk, reset (async, active-low)
//   pc_current, call, call_target, ret, irq_take, err_clr  : requests
//   load, load_address                                    : jump request to PC
//   busy, depth, empty, full                              : stack status
//   overflow_err, underflow_err                           : sticky errors
//
// state | meaning
// IDLE  | accepting requests (priority irq_take > call > ret)
// READ  | pop read issued, the RAM output is captured into load_address
// LOAD  | load pulse scheduled for the next cycle
module pc_link_stack #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    pc_current,
  input  logic             call,
  input  logic [AW-1:0]    call_target,
  input  logic             ret,
  input  logic             irq_take,
  input  logic             err_clr,
  output logic             load,
  output logic [AW-1:0]    load_address,
  output logic             busy,
  output logic [PTR_W:0]   depth,
  output logic             empty,
  output logic             full,
  output logic             overflow_err,
  output logic             underflow_err
);

  typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;

  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_rd_data;
  logic [AW-1:0]      r_load_address;
  logic [PTR_W:0]     r_depth, w_depth_nxt;
  logic               r_empty, r_full, r_load, r_ovf, r_unf;

  logic               w_idle, w_push_req, w_push, w_ovf_set;
  logic               w_ret_req, w_pop, w_unf_set, w_jump;
  logic [PTR_W-1:0]   w_wr_idx, w_rd_idx;

  assign w_idle     = (r_state == IDLE);
  assign w_push_req = w_idle & (irq_take | call);
  assign w_push     = w_push_req & ~r_full;
  assign w_ovf_set  = w_push_req & r_full;
  // A call jumps even when the push is refused because the stack is full.
  assign w_jump     = w_idle & ~irq_take & call;
  assign w_ret_req  = w_idle & ~irq_take & ~call & ret;
  assign w_pop      = w_ret_req & ~r_empty;
  assign w_unf_set  = w_ret_req & r_empty;

  // When the stack is full the low bits wrap to 0, and 0-1 then gives DEPTH-1.
  assign w_wr_idx = r_depth[PTR_W-1:0];
  assign w_rd_idx = r_depth[PTR_W-1:0] - (PTR_W)'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_state_nxt = READ;
      READ:    w_state_nxt = LOAD;
      LOAD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_depth_nxt = r_depth;
    if (w_push)     w_depth_nxt = r_depth + CNT_ONE;
    else if (w_pop) w_depth_nxt = r_depth - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_depth <= w_depth_nxt;
      r_empty <= (w_depth_nxt == '0);
      r_full  <= (w_depth_nxt == CNT_FULL);
    end
  end

  // The storage has no reset so that it can map onto a synchronous-read RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_idx] <= pc_current + AW'(1);
    if (w_pop)  r_rd_data <= r_mem[w_rd_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load         <= 1'b0;
      r_load_address <= '0;
    end else begin
      r_load <= w_jump | (r_state == LOAD);
      if (w_jump)                r_load_address <= call_target;
      else if (r_state == READ)  r_load_address <= r_rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_unf_set)    r_unf <= 1'b1;
      else if (err_clr) r_unf <= 1'b0;
    end
  end

  assign load          = r_load;
  assign load_address  = r_load_address;
  assign busy          = ~w_idle;
  assign depth         = r_depth;
  assign empty         = r_empty;
  assign full          = r_full;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: tb/tb_pc_link_stack.sv
module tb_pc_link_stack;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current, call_target;
  logic        call, ret, irq_take, err_clr;
  logic        load, busy, empty, full, overflow_err, underflow_err;
  logic [31:0] load_address;
  logic [4:0]  depth;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: a queue of return addresses plus a countdown for an
  // outstanding pop.
  logic [31:0] m_stk[$];
  logic        m_load, m_ovf, m_unf;
  logic [31:0] m_laddr, m_pop;
  int          m_left;

  pc_link_stack dut (
    .clk(clk), .reset(reset), .pc_current(pc_current), .call(call),
    .call_target(call_target), .ret(ret), .irq_take(irq_take), .err_clr(err_clr),
    .load(load), .load_address(load_address), .busy(busy), .depth(depth),
    .empty(empty), .full(full), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("load", {31'd0, load}, {31'd0, m_load});
    check("load_address", load_address, m_laddr);
    check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check("depth", {27'd0, depth}, m_stk.size());
    check("empty", {31'd0, empty}, {31'd0, (m_stk.size() == 0)});
    check("full", {31'd0, full}, {31'd0, (m_stk.size() == DEPTH)});
    check("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
    check("underflow_err", {31'd0, underflow_err}, {31'd0, m_unf});
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_load = 0; m_ovf = 0; m_unf = 0; m_laddr = '0; m_pop = '0; m_left = 0;
  endtask

  task automatic model_update(input logic i_irq, input logic i_call, input logic [31:0] i_tgt,
                              input logic i_ret, input logic [31:0] i_pc, input logic i_clr);
    logic so, su;
    so = 0; su = 0; m_load = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 1) m_laddr = m_pop;
      if (m_left == 0) m_load = 1;
    end else if (i_irq) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(i_pc + 32'd1);
      else so = 1;
    end else if (i_call) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(i_pc + 32'd1);
      else so = 1;
      m_load = 1; m_laddr = i_tgt;
    end else if (i_ret) begin
      if (m_stk.size() == 0) su = 1;
      else begin m_pop = m_stk.pop_back(); m_left = 2; end
    end
    m_ovf = so ? 1'b1 : (i_clr ? 1'b0 : m_ovf);
    m_unf = su ? 1'b1 : (i_clr ? 1'b0 : m_unf);
  endtask

  task automatic step(input logic i_irq, input logic i_call, input logic [31:0] i_tgt,
                      input logic i_ret, input logic [31:0] i_pc, input logic i_clr);
    irq_take = i_irq; call = i_call; call_target = i_tgt; ret = i_ret;
    pc_current = i_pc; err_clr = i_clr;
    @(posedge clk);
    #1;
    model_update(i_irq, i_call, i_tgt, i_ret, i_pc, i_clr);
    check_all();
    irq_take = 0; call = 0; ret = 0; err_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    reset = 0; irq_take = 0; call = 0; ret = 0; err_clr = 0;
    pc_current = '0; call_target = '0;
    model_reset();
    #12;
    check_all();
    reset = 1;

    // single call / ret
    step(0, 1, 32'h100, 0, 32'h20, 0);
    check("call_jump", load_address, 32'h100);
    step(0, 0, 32'h0, 1, 32'h105, 0);
    idle(3);
    check("ret_addr", load_address, 32'h21);

    // nested calls and returns
    step(0, 1, 32'h200, 0, 32'h10, 0);
    step(0, 1, 32'h300, 0, 32'h200, 0);
    step(0, 1, 32'h400, 0, 32'h300, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, 1, 32'h0, 0);
      idle(2);
    end
    idle(1);

    // fill, then overflow on the 17th call
    for (int k = 0; k < DEPTH; k++) step(0, 1, 32'h1000 + k, 0, 32'h50 + k, 0);
    step(0, 1, 32'h400, 0, 32'h77, 0);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_flag", {31'd0, overflow_err}, 32'd1);
    step(0, 0, 32'h0, 0, 32'h0, 1);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 32'h0, 1, 32'h0, 0);
      idle(2);
    end
    idle(1);

    // underflow, then irq wrap of the return address
    step(0, 0, 32'h0, 1, 32'h0, 0);
    idle(1);
    step(1, 0, 32'h0, 0, 32'hFFFF_FFFF, 1);
    step(0, 0, 32'h0, 1, 32'h0, 0);
    idle(3);
    check("irq_wrap", load_address, 32'h0);

    // irq and call together, then a call while READ is ignored
    step(1, 1, 32'h900, 0, 32'h40, 0);
    step(0, 0, 32'h0, 1, 32'h0, 0);
    step(0, 1, 32'h999, 0, 32'h60, 0);
    idle(3);
    check("irq_over_call", load_address, 32'h41);

    // reset during READ abandons the pop
    step(0, 1, 32'h500, 0, 32'h80, 0);
    idle(1);
    step(0, 0, 32'h0, 1, 32'h0, 0);
    #2 reset = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1;
    idle(4);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic r_i, r_c, r_r, r_e;
      r_i = ($urandom_range(0, 9) == 0);
      r_c = ($urandom_range(0, 3) == 0);
      r_r = ($urandom_range(0, 2) == 0);
      r_e = ($urandom_range(0, 7) == 0);
      step(r_i, r_c, $urandom, r_r, $urandom, r_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
